timer_sched: RTL and testbench
==============================

TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter: WIDTH, default 4, width of the shared up-counter and of each requested length.
REQ-003 Port: clk  input  1  clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req  input  NREQ  per-requester timing request, level; held high until matching done, or dropped to abort.
REQ-006 Port: req_len  input  NREQ*WIDTH  terminal count per requester; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 Port: gnt  output  NREQ  one-hot grant; all zero when idle.
REQ-008 Port: done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: cnt  output  WIDTH  current value of the shared counter.

Function
REQ-011 FSM states SHALL be IDLE, COUNT and DONE, and all outputs SHALL be registered.
REQ-012 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0, done=0, cnt=0 and busy=0.
REQ-013 Arbitration in IDLE with req!=0 SHALL be round-robin: search starts at index (last+1) mod NREQ, where last is the previously granted index.
REQ-014 The winner's req_len SHALL be latched as target on the arbitration edge, and later req_len changes SHALL be ignored until the next grant.
REQ-015 On the arbitration edge, the next state SHALL be COUNT, with gnt set one-hot to the winner, cnt=0 and last=winner.
REQ-016 In COUNT with req[winner]=1 and cnt!=target, cnt SHALL increment by 1 per cycle.
REQ-017 In COUNT with req[winner]=1 and cnt==target, the next state SHALL be DONE with done[winner]=1 and cnt held at target.
REQ-018 Timing: a grant SHALL give target+1 COUNT cycles (cnt values 0..target), then exactly one DONE cycle; target=0 gives one COUNT cycle.
REQ-019 cnt SHALL never wrap: target <= 2^WIDTH-1 and counting stops at target.
REQ-020 In DONE, gnt SHALL remain asserted, done SHALL be high for exactly that one cycle, and the next state SHALL be IDLE with gnt=0, done=0 and cnt=0.
REQ-021 There SHALL be at least one IDLE cycle between consecutive grants; req is arbitrated only in IDLE.
REQ-022 Abort: if req[winner]=0 is sampled in COUNT, the next state SHALL be IDLE with gnt=0, cnt=0 and no done pulse, and last SHALL still be updated to that winner.
REQ-023 req[winner] dropping during DONE SHALL have no effect, and the done pulse SHALL still be issued.
REQ-024 Requests from non-granted indices SHALL be ignored in COUNT and DONE; they remain pending if held.
REQ-025 gnt and done SHALL never have more than one bit set, and done SHALL only assert on the bit set in gnt.

Reset
REQ-026 With rst=1 sampled at an edge, the next state SHALL be IDLE with gnt=0, done=0, busy=0, cnt=0, target=0 and last=NREQ-1, so index 0 has top priority after reset.
REQ-027 rst SHALL take priority over all other inputs in every state; a reset during COUNT or DONE SHALL suppress any pending done pulse.
REQ-028 rst asserted together with req SHALL produce no grant on that edge, and arbitration SHALL resume on the first edge with rst=0.

Verification
REQ-029 Single request: rst, then req=0001 with len0=3 -> gnt=0001 for 5 cycles, cnt 0,1,2,3,3, done=0001 in the 5th cycle, then idle.
REQ-030 Round-robin: req=1111 held, all lens=1 -> grant order 0,1,2,3,0, with one IDLE cycle between each grant.
REQ-031 Zero length and max length: len=0 -> one COUNT cycle then done; len=15 -> cnt reaches 15, holds, no wrap to 0.
REQ-032 Abort: req0 len=8, drop req0 when cnt=4 -> next cycle gnt=0, cnt=0, no done; pending req1 is granted after one IDLE cycle.
REQ-033 Reset mid-operation: rst=1 while cnt=2 -> next cycle all outputs 0; after release, req=1010 grants index 1 first.
REQ-034 Every scenario SHALL check that gnt and done are one-hot-or-zero, that done is a subset of gnt, and that busy equals (gnt!=0) on every cycle.

Source files
------------

// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - round-robin arbitrated shared interval timer
//
// Grants one requester at a time the shared up-counter. The winner's
// req_len is captured as the terminal count; the counter runs 0..target
// (one cycle per value), then a single DONE cycle pulses done to the
// winner. Dropping the winner's req while counting aborts with no done.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      per-requester level request
//   req_len  per-requester terminal count, requester i at [i*WIDTH +: WIDTH]
//   gnt      one-hot grant (registered), zero when idle
//   done     one-cycle completion pulse on the granted bit (registered)
//   busy     high whenever not idle (registered)
//   cnt      shared counter value (registered)
module timer_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_len,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [WIDTH-1:0]        cnt
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [NREQ-1:0]    gnt_n, done_n;
    logic               busy_n;
    logic [WIDTH-1:0]   cnt_n, target, target_n;
    // last doubles as the current winner's index while COUNT/DONE.
    logic [LW-1:0]      last, last_n;

    // Round-robin search scratch.
    logic               found;
    logic [LW-1:0]      win;
    int                 idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            done   <= '0;
            busy   <= 1'b0;
            cnt    <= '0;
            target <= '0;
            last   <= LW'(NREQ - 1);
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            done   <= done_n;
            busy   <= busy_n;
            cnt    <= cnt_n;
            target <= target_n;
            last   <= last_n;
        end
    end

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        done_n   = '0;
        cnt_n    = cnt;
        target_n = target;
        last_n   = last;
        found    = 1'b0;
        win      = '0;
        idx      = 0;

        // Search starts just after the previous winner so it gets lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx[LW-1:0];
            end
        end

        case (state)
            IDLE: begin
                gnt_n = '0;
                cnt_n = '0;
                if (found) begin
                    state_n     = COUNT;
                    gnt_n[win]  = 1'b1;
                    last_n      = win;
                    target_n    = req_len[int'(win)*WIDTH +: WIDTH];
                end
            end
            COUNT: begin
                if (!req[last]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == target) begin
                    state_n = DONE;
                    done_n  = gnt;
                end else begin
                    cnt_n = cnt + WIDTH'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                gnt_n   = '0;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                cnt_n   = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - directed vector bench for timer_sched
module tb_timer_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  cnt;

    int errors = 0;
    int checks = 0;
    bit inv_en = 0;

    timer_sched #(.NREQ(4), .WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_len (req_len),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .cnt     (cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic        busy;
        logic [3:0]  cnt;
        string       name;
    } vec_t;

    vec_t vq[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [15:0] ln,
                                input logic [3:0] eg, input logic [3:0] ed, input logic eb,
                                input logic [3:0] ec, input string nm);
        vec_t v;
        v.rst = r; v.req = rq; v.len = ln;
        v.gnt = eg; v.done = ed; v.busy = eb; v.cnt = ec; v.name = nm;
        return v;
    endfunction

    function automatic void add(input logic r, input logic [3:0] rq, input logic [15:0] ln,
                                input logic [3:0] eg, input logic [3:0] ed, input logic eb,
                                input logic [3:0] ec, input string nm);
        vq.push_back(mk(r, rq, ln, eg, ed, eb, ec, nm));
    endfunction

    task automatic apply(input vec_t v, input int i);
        rst     = v.rst;
        req     = v.req;
        req_len = v.len;
        @(posedge clk);
        #1;
        chk($sformatf("%s[%0d].gnt",  v.name, i), 32'(gnt),  32'(v.gnt));
        chk($sformatf("%s[%0d].done", v.name, i), 32'(done), 32'(v.done));
        chk($sformatf("%s[%0d].busy", v.name, i), 32'(busy), 32'(v.busy));
        chk($sformatf("%s[%0d].cnt",  v.name, i), 32'(cnt),  32'(v.cnt));
    endtask

    // Structural invariants on every cycle, sampled mid-period.
    always @(negedge clk) begin
        if (inv_en) begin
            chk("inv.gnt_onehot0",  32'($onehot0(gnt)), 32'(1));
            chk("inv.done_onehot0", 32'($onehot0(done)), 32'(1));
            chk("inv.done_in_gnt",  32'(done & ~gnt), 32'(0));
            chk("inv.busy_eq_gnt",  32'(busy), 32'(gnt != 4'b0));
        end
    end

    initial begin
        rst = 1; req = 0; req_len = 0;

        // Single request, len0=3; req_len changed after grant must be ignored.
        add(1, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, "reset");
        add(0, 4'h1, 16'h0003, 4'h1, 4'h0, 1, 4'd0, "single");
        add(0, 4'h1, 16'h0000, 4'h1, 4'h0, 1, 4'd1, "single");
        add(0, 4'h1, 16'h0000, 4'h1, 4'h0, 1, 4'd2, "single");
        add(0, 4'h1, 16'h0000, 4'h1, 4'h0, 1, 4'd3, "single");
        add(0, 4'h1, 16'h0000, 4'h1, 4'h1, 1, 4'd3, "single_done");
        add(0, 4'h1, 16'h0000, 4'h0, 4'h0, 0, 4'd0, "single_idle");
        add(0, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, "single_idle2");

        // Round-robin: all requesting, all lens=1 -> order 0,1,2,3,0.
        add(1, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, "rr_reset");
        for (int g = 0; g < 5; g++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (g % 4);
            add(0, 4'hF, 16'h1111, oh,   4'h0, 1, 4'd0, "rr_c0");
            add(0, 4'hF, 16'h1111, oh,   4'h0, 1, 4'd1, "rr_c1");
            add(0, 4'hF, 16'h1111, oh,   oh,   1, 4'd1, "rr_done");
            add(0, 4'hF, 16'h1111, 4'h0, 4'h0, 0, 4'd0, "rr_idle");
        end

        // Zero length, then max length with no wrap.
        add(1, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, "len_reset");
        add(0, 4'h1, 16'h0000, 4'h1, 4'h0, 1, 4'd0, "len0_c0");
        add(0, 4'h1, 16'h0000, 4'h1, 4'h1, 1, 4'd0, "len0_done");
        add(0, 4'h1, 16'h0000, 4'h0, 4'h0, 0, 4'd0, "len0_idle");
        add(0, 4'h1, 16'h000F, 4'h1, 4'h0, 1, 4'd0, "len15_c0");
        for (int c = 1; c <= 15; c++)
            add(0, 4'h1, 16'h0000, 4'h1, 4'h0, 1, 4'(c), "len15_cnt");
        add(0, 4'h1, 16'h0000, 4'h1, 4'h1, 1, 4'd15, "len15_done");
        add(0, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, "len15_idle");

        // Abort: req0 len=8 dropped at cnt=4; pending req1 (len=2) follows.
        add(1, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, "abort_reset");
        add(0, 4'h3, 16'h0028, 4'h1, 4'h0, 1, 4'd0, "abort_cnt");
        for (int c = 1; c <= 4; c++)
            add(0, 4'h3, 16'h0028, 4'h1, 4'h0, 1, 4'(c), "abort_cnt");
        add(0, 4'h2, 16'h0028, 4'h0, 4'h0, 0, 4'd0, "abort_drop");
        add(0, 4'h2, 16'h0028, 4'h2, 4'h0, 1, 4'd0, "abort_r1_c0");
        add(0, 4'h2, 16'h0028, 4'h2, 4'h0, 1, 4'd1, "abort_r1_c1");
        add(0, 4'h2, 16'h0028, 4'h2, 4'h0, 1, 4'd2, "abort_r1_c2");
        add(0, 4'h2, 16'h0028, 4'h2, 4'h2, 1, 4'd2, "abort_r1_done");
        add(0, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, "abort_idle");

        apply(vq[0], 0);
        inv_en = 1;
        for (int i = 1; i < vq.size(); i++)
            apply(vq[i], i);

        // Reset mid-count, with req held: no grant on the reset edge.
        apply(mk(0, 4'h1, 16'h0005, 4'h1, 4'h0, 1, 4'd0, "rmid_c0"), 0);
        apply(mk(0, 4'h1, 16'h0005, 4'h1, 4'h0, 1, 4'd1, "rmid_c1"), 1);
        apply(mk(0, 4'h1, 16'h0005, 4'h1, 4'h0, 1, 4'd2, "rmid_c2"), 2);
        apply(mk(1, 4'h1, 16'h0005, 4'h0, 4'h0, 0, 4'd0, "rmid_rst"), 3);
        // last back to 3 after reset, so index 1 wins over 3.
        apply(mk(0, 4'hA, 16'h0000, 4'h2, 4'h0, 1, 4'd0, "rmid_rr"), 4);
        apply(mk(0, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, "rmid_abort"), 5);

        // Reset on the edge that would enter DONE suppresses the pulse.
        apply(mk(0, 4'h1, 16'h0000, 4'h1, 4'h0, 1, 4'd0, "rdone_c0"), 0);
        apply(mk(1, 4'h1, 16'h0000, 4'h0, 4'h0, 0, 4'd0, "rdone_rst"), 1);
        apply(mk(0, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, "rdone_idle"), 2);

        @(posedge clk);
        #1;
        inv_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
